// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data memory arbiter
//
// Purpose: arbitration state encoding and requester index constants used by
//          dmem_arbiter and its round-robin grant sub-module rr_arb2.
// Ports:   none (package).
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Bit positions of each requester in the 2-bit request/grant vectors.
  localparam bit REQ_CPU = 1'b0;
  localparam bit REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant with last-winner pointer
//
// Purpose: grants at most one of two requesters per cycle. On contention the
//          requester that did not win last is granted. allow_mask removes a
//          requester from consideration (used to lock out the cpu).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     requests, indexed by REQ_CPU / REQ_DBG
//   allow_mask   1 = requester may be granted
//   ptr_to_dbg   force the last-winner pointer to dbg (cpu wins next contention)
//   gnt[1:0]     one-hot (or zero) grant, combinational
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] allow_mask,
  input  logic       ptr_to_dbg,
  output logic [1:0] gnt
);

  logic       last_dbg_q;
  logic       last_dbg_d;
  logic [1:0] eligible;

  always_comb begin
    eligible   = req & allow_mask;
    gnt        = 2'b00;
    last_dbg_d = last_dbg_q;

    if (eligible == 2'b11) begin
      if (last_dbg_q) begin
        gnt[REQ_CPU] = 1'b1;
      end else begin
        gnt[REQ_DBG] = 1'b1;
      end
    end else begin
      gnt = eligible;
    end

    // The pointer remembers who won; an explicit override wins over it.
    if (ptr_to_dbg) begin
      last_dbg_d = 1'b1;
    end else if (gnt[REQ_CPU]) begin
      last_dbg_d = 1'b0;
    end else if (gnt[REQ_DBG]) begin
      last_dbg_d = 1'b1;
    end
  end

  // Reset value points at dbg so the cpu wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - cpu / debug arbiter in front of a single-port data memory
//
// Purpose: shares one synchronous-read data memory between the core load/store
//          port (cpu) and the debug/loader port (dbg). One access per cycle,
//          round-robin on contention, dbg lock for atomic multi-word transfers,
//          cpu stall output and a saturating stall-cycle counter.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata             cpu request (held until cpu_gnt)
//   cpu_gnt, cpu_stall                cpu accepted / cpu must hold
//   cpu_rvalid, cpu_rdata             cpu read return, one cycle after grant
//   dbg_req/we/addr/wdata/lock        debug request and lock request
//   dbg_gnt, dbg_rvalid, dbg_rdata    debug grant and read return
//   lock_held                         dbg owns the memory exclusively
//   mem_en/we/addr/wdata, mem_rdata   data memory interface
//   stall_cnt                         saturating count of cpu_stall cycles
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              lock_held,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_owner_dbg_q, rd_owner_dbg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] req_vec;
  logic [1:0] allow_mask;
  logic [1:0] gnt_vec;
  logic       ptr_to_dbg;

  // Requests are masked while reset is asserted so every output, including
  // the combinational grant path, is 0 during reset.
  always_comb begin
    req_vec          = 2'b00;
    req_vec[REQ_CPU] = cpu_req & reset_n;
    req_vec[REQ_DBG] = dbg_req & reset_n;
    allow_mask          = 2'b11;
    allow_mask[REQ_CPU] = (state_q == ARB_RR);
  end

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rst_n      (reset_n),
    .req        (req_vec),
    .allow_mask (allow_mask),
    .ptr_to_dbg (ptr_to_dbg),
    .gnt        (gnt_vec)
  );

  assign cpu_gnt   = gnt_vec[REQ_CPU];
  assign dbg_gnt   = gnt_vec[REQ_DBG];
  assign cpu_stall = req_vec[REQ_CPU] & ~cpu_gnt;
  assign lock_held = (state_q == ARB_LOCKED);

  // Lock FSM. The lock is only taken on a dbg grant, and released when
  // dbg_lock is seen low while locked.
  always_comb begin
    state_d    = state_q;
    ptr_to_dbg = 1'b0;
    case (state_q)
      ARB_RR: begin
        if (dbg_gnt && dbg_lock) begin
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (!dbg_lock) begin
          state_d    = ARB_RR;
          ptr_to_dbg = 1'b1;
        end
      end
      default: begin
        state_d = ARB_RR;
      end
    endcase
  end

  // Memory request mux; all-zero when idle.
  always_comb begin
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Read-return tracking: one outstanding read, tagged with its owner.
  always_comb begin
    rd_valid_d     = mem_en & ~mem_we;
    rd_owner_dbg_d = dbg_gnt;
  end

  assign cpu_rvalid = rd_valid_q & ~rd_owner_dbg_q;
  assign dbg_rvalid = rd_valid_q & rd_owner_dbg_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB_RR;
      rd_valid_q     <= 1'b0;
      rd_owner_dbg_q <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      rd_valid_q     <= rd_valid_d;
      rd_owner_dbg_q <= rd_owner_dbg_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, lock_held;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] stall_cnt;

  logic          n_cpu_gnt, n_cpu_stall, n_cpu_rvalid, n_dbg_gnt, n_dbg_rvalid, n_lock_held;
  logic [DW-1:0] n_cpu_rdata, n_dbg_rdata;
  logic          n_mem_en, n_mem_we;
  logic [AW-1:0] n_mem_addr;
  logic [DW-1:0] n_mem_wdata;
  logic [3:0]    n_stall_cnt;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .lock_held(lock_held), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_narrow (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(n_cpu_gnt), .cpu_stall(n_cpu_stall), .cpu_rvalid(n_cpu_rvalid), .cpu_rdata(n_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(n_dbg_gnt), .dbg_rvalid(n_dbg_rvalid), .dbg_rdata(n_dbg_rdata),
    .lock_held(n_lock_held), .mem_en(n_mem_en), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
    .mem_wdata(n_mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(n_stall_cnt)
  );

  // Bench-owned synchronous-read memory attached to the main instance.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lock ownership, who won last, the pending read and the
  // memory contents as the requesters should see them.
  bit            lock_m, last_dbg_m, pend_m, pend_dbg_m;
  logic [DW-1:0] pend_data_m;
  logic [DW-1:0] shadow [0:255];
  int            cnt_m, cnt4_m;
  logic          e_cg, e_dg, e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);     chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_cpu_stall", cpu_stall, 0); chk("rst_lock_held", lock_held, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0); chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0); chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_mem_en", mem_en, 0);       chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);   chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall_cnt", stall_cnt, 0); chk("rst_n_stall_cnt", n_stall_cnt, 0);
      lock_m = 0; last_dbg_m = 1; pend_m = 0; pend_dbg_m = 0; pend_data_m = '0;
      cnt_m = 0; cnt4_m = 0;
    end else begin
      if (lock_m) begin
        e_cg = 1'b0; e_dg = dbg_req;
      end else if (cpu_req && dbg_req) begin
        e_cg = last_dbg_m; e_dg = !last_dbg_m;
      end else begin
        e_cg = cpu_req; e_dg = dbg_req;
      end
      e_en    = e_cg | e_dg;
      e_we    = e_cg ? cpu_we    : (e_dg ? dbg_we    : 1'b0);
      e_addr  = e_cg ? cpu_addr  : (e_dg ? dbg_addr  : '0);
      e_wdata = e_cg ? cpu_wdata : (e_dg ? dbg_wdata : '0);

      chk("cpu_gnt", cpu_gnt, e_cg);
      chk("dbg_gnt", dbg_gnt, e_dg);
      chk("cpu_stall", cpu_stall, cpu_req & ~e_cg);
      chk("lock_held", lock_held, lock_m);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("cpu_rvalid", cpu_rvalid, pend_m & ~pend_dbg_m);
      chk("dbg_rvalid", dbg_rvalid, pend_m & pend_dbg_m);
      chk("cpu_rdata", cpu_rdata, (pend_m && !pend_dbg_m) ? pend_data_m : '0);
      chk("dbg_rdata", dbg_rdata, (pend_m && pend_dbg_m) ? pend_data_m : '0);
      chk("stall_cnt", stall_cnt, cnt_m);
      chk("n_stall_cnt", n_stall_cnt, cnt4_m);

      if (e_en) last_dbg_m = e_dg;
      if (!lock_m && e_dg && dbg_lock) begin
        lock_m = 1;
      end else if (lock_m && !dbg_lock) begin
        lock_m = 0; last_dbg_m = 1;
      end
      pend_m      = e_en && !e_we;
      pend_dbg_m  = e_dg;
      pend_data_m = shadow[e_addr];
      if (e_en && e_we) shadow[e_addr] = e_wdata;
      if (cpu_req && !e_cg) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt4_m < 15) cnt4_m++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #2;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  logic [3:0] alt_pat;

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      mem[i]    <= DW'(i * 3 + 7);
      shadow[i]  = DW'(i * 3 + 7);
    end
    mem[5]    <= 32'h0000_002A;
    shadow[5]  = 32'h0000_002A;
    mem_rdata <= '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // Single cpu read after reset.
    cpu_req = 1; cpu_addr = 8'h05;
    mid(); chk("t1_cpu_gnt", cpu_gnt, 1);
    tick(); cpu_req = 0;
    mid();
    chk("t1_cpu_rvalid", cpu_rvalid, 1); chk("t1_cpu_rdata", cpu_rdata, 42);
    chk("t1_dbg_rvalid", dbg_rvalid, 0); chk("t1_stall_cnt", stall_cnt, 0);
    tick();

    // Continuous contention from a fresh reset: cpu, dbg, cpu, dbg.
    reset_n = 0; tick(); reset_n = 1;
    alt_pat = 4'b0101;
    cpu_req = 1; cpu_addr = 8'h01; dbg_req = 1; dbg_addr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t2_cpu_gnt", cpu_gnt, alt_pat[k]);
      chk("t2_cpu_stall", cpu_stall, !alt_pat[k]);
      tick();
    end
    idle_inputs();
    mid(); chk("t2_stall_cnt", stall_cnt, 2);
    tick();

    // cpu-only access so dbg wins the next contention and takes the lock.
    cpu_req = 1; cpu_addr = 8'h01; tick();
    dbg_lock = 1; dbg_req = 1; dbg_we = 1;
    for (int k = 0; k < 4; k++) begin
      dbg_addr = AW'(8'h10 + k); dbg_wdata = DW'(k + 1);
      mid();
      chk("t3_dbg_gnt", dbg_gnt, 1); chk("t3_cpu_gnt", cpu_gnt, 0);
      chk("t3_lock_held", lock_held, k > 0);
      tick();
    end
    dbg_req = 0; dbg_we = 0; dbg_lock = 0;
    mid(); chk("t3_lock_tail", lock_held, 1); chk("t3_cpu_blocked", cpu_gnt, 0);
    tick();
    mid(); chk("t3_cpu_after", cpu_gnt, 1); chk("t3_unlocked", lock_held, 0);
    tick();
    for (int k = 0; k < 4; k++) chk("t3_mem", mem[8'h10 + k], DW'(k + 1));

    // dbg_lock without dbg_req does nothing.
    dbg_lock = 1;
    mid(); chk("t3b_cpu_gnt", cpu_gnt, 1);
    tick(); cpu_req = 0; dbg_lock = 0;
    mid(); chk("t3b_no_lock", lock_held, 0);
    tick();

    // cpu store then dbg read of the same word.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h1C; cpu_wdata = 32'd20;
    mid(); chk("t4_cpu_gnt", cpu_gnt, 1);
    tick(); idle_inputs();
    dbg_req = 1; dbg_addr = 8'h1C;
    mid(); chk("t4_dbg_gnt", dbg_gnt, 1);
    tick(); idle_inputs();
    mid();
    chk("t4_dbg_rvalid", dbg_rvalid, 1); chk("t4_dbg_rdata", dbg_rdata, 20);
    chk("t4_cpu_rvalid", cpu_rvalid, 0);
    tick();

    // Reset mid-lock with a dbg read in flight.
    dbg_lock = 1; dbg_req = 1; dbg_addr = 8'h05;
    tick();
    dbg_req = 0; cpu_req = 1; cpu_addr = 8'h03;
    #1;
    chk("t5_pre_lock", lock_held, 1); chk("t5_pre_rvalid", dbg_rvalid, 1);
    chk("t5_pre_stall_cnt", stall_cnt != 0, 1);
    reset_n = 0;
    #1;
    chk("t5_lock_held", lock_held, 0); chk("t5_dbg_rvalid", dbg_rvalid, 0);
    chk("t5_dbg_rdata", dbg_rdata, 0); chk("t5_cpu_stall", cpu_stall, 0);
    chk("t5_mem_en", mem_en, 0);       chk("t5_stall_cnt", stall_cnt, 0);
    tick();
    reset_n = 1; idle_inputs();
    mid(); chk("t5_post_rvalid", dbg_rvalid, 0); chk("t5_post_lock", lock_held, 0);
    tick();

    // Saturation: dbg holds the lock while the cpu stalls 2^4 + 5 cycles.
    dbg_lock = 1; dbg_req = 1; dbg_addr = 8'h00;
    tick();
    dbg_req = 0; cpu_req = 1; cpu_addr = 8'h02;
    repeat (21) tick();
    cpu_req = 0; dbg_lock = 0;
    mid(); chk("t6_stall_cnt", stall_cnt, 21); chk("t6_n_stall_cnt", n_stall_cnt, 4'hF);
    tick();
    mid(); chk("t6_unlocked", lock_held, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
